judge_multi: RTL and testbench
==============================

JUDGE_MULTI -- requirements
Module: judge_multi

Interface
REQ-001 Parameter N_CHAR, default 8, number of character slots per frame.
REQ-002 Parameter IDX_W, default 4, width of one character index.
REQ-003 Parameter DIFF_W, default 16, width of one match-difference score.
REQ-004 Parameter CNT_W, default 8, width of the frame counter and min_counter.
REQ-005 Port clk  in  1  sole clock, all logic on its rising edge.
REQ-006 Port rst  in  1  asynchronous, active-high reset.
REQ-007 Port max_diff  in  DIFF_W  highest diff score that accepts a slot.
REQ-008 Port min_continue  in  4  number of identical consecutive good frames needed for a result.
REQ-009 Port min_counter  in  CNT_W  frame budget per search, used for timeout.
REQ-010 Port slot_mask  in  N_CHAR  bit i=1 means slot i takes part in judging.
REQ-011 Port char_index_c  in  N_CHAR*IDX_W  slot i index at bits [i*IDX_W +: IDX_W].
REQ-012 Port char_diff_c  in  N_CHAR*DIFF_W  slot i diff at bits [i*DIFF_W +: DIFF_W].
REQ-013 Port char_valid_c  in  1  single-cycle frame strobe.
REQ-014 Port res_index  out  N_CHAR*IDX_W  confirmed indices, with masked-off slots forced to 0.
REQ-015 Port res_valid  out  1  result available.
REQ-016 Port res_ready  in  1  consumer accepts the result.
REQ-017 Port timeout  out  1  single-cycle pulse when the frame budget is exhausted.
REQ-018 Port busy  out  1  high when state is not IDLE.

Function
REQ-019 Stage 1: on char_valid_c, register the masked indices and a good flag; good = every masked slot has diff <= max_diff (unsigned), and slot_mask != 0.
REQ-020 Stage 2 is the state machine, with states IDLE, COLLECT and DONE.
REQ-021 IDLE: the first stage-1 frame moves the FSM to COLLECT, sets frame_cnt=1, and applies the streak rule to that frame.
REQ-022 Streak rule, good frame equal to candidate: streak+1, saturating at 15.
REQ-023 Streak rule, good frame that differs from candidate: candidate=frame, streak=1.
REQ-024 Streak rule, bad frame: streak=0 and candidate keeps its value.
REQ-025 Effective threshold = max(min_continue,1).
REQ-026 When streak reaches the threshold, res_index=candidate, res_valid=1 and the FSM enters DONE; res_valid rises 2 cycles after the char_valid_c sample.
REQ-027 DONE: hold res_index and res_valid until res_valid && res_ready, then go to IDLE, clearing streak and frame_cnt.
REQ-028 Frames that arrive in DONE are dropped and do not alter candidate or streak.
REQ-029 COLLECT: each frame increments frame_cnt, which saturates at all-ones.
REQ-030 A frame in which the streak threshold and the timeout condition are both met resolves to the result, so DONE wins over timeout.
REQ-031 Inputs max_diff, min_continue, min_counter and slot_mask are sampled per frame, and changing them mid-search affects only later frames.
REQ-032 A back-to-back char_valid_c on consecutive cycles is processed frame-by-frame with no frame lost.

Reset
REQ-033 rst asserted at any time, including mid-search or in DONE, immediately forces IDLE, res_valid=0, res_index=0, timeout=0, busy=0, streak=0, frame_cnt=0, candidate=0 and clears the stage-1 registers.
REQ-034 The first frame is accepted on the first char_valid_c that is sampled after rst deasserts.

Configuration
REQ-035 Macro JUDGE_MULTI_TIMEOUT_EN, when defined, means: in COLLECT, when frame_cnt reaches min_counter (min_counter != 0) without a result, pulse timeout for 1 cycle and return to IDLE with streak, frame_cnt and candidate cleared.
REQ-036 Without JUDGE_MULTI_TIMEOUT_EN: no timeout logic is built, timeout is tied 0, min_counter is ignored, and the search runs until a result.

Verification
REQ-037 Scenario, basic: N_CHAR=8, mask=8'hF8, max_diff=30, min_continue=2, two frames with indices {4,3,2,1,0} and diffs 0x10 -> res_valid 2 cycles after the 2nd strobe, res_index slots7..3 = 4,3,2,1,0, slots2..0 = 0.
REQ-038 Scenario, mismatch: frames A,B,A,A with min_continue=2 -> exactly one result, on the 4th frame, equal to A.
REQ-039 Scenario, bad diff: masked diffs 0x50 with max_diff=30 repeated 12 times, min_counter=10, macro defined -> timeout pulse on frame 10, busy low afterwards, no res_valid.
REQ-040 Scenario, backpressure: res_ready=0 for 20 cycles while 3 more frames arrive -> res_index stable, handshake completes when res_ready=1, IDLE next cycle.
REQ-041 Scenario, reset mid-search: rst pulsed after 1 of 2 needed good frames -> all outputs 0, and a single later frame does not produce a result.
REQ-042 Scenario, macro undefined: 12 bad frames then 2 good frames -> timeout never asserted, result produced on the 14th frame.

Source files
------------

// File: rtl/judge_multi.sv
// judge_multi -- multi-character recognition judge.
//
// Each frame carries one character index and one match-difference score per
// slot. Stage 1 masks the indices and flags the frame "good" when every
// participating slot scores within max_diff. Stage 2 is an IDLE/COLLECT/DONE
// state machine that tracks a candidate frame and a streak of identical good
// frames. Once the streak reaches max(min_continue,1) the candidate is
// published and held until the consumer takes it.
//
// Optional feature: define JUDGE_MULTI_TIMEOUT_EN to abandon a search when
// its frame count reaches min_counter. Without it timeout is tied low and
// min_counter is ignored.
//
// Ports:
//   clk, rst (async, active-high)
//   max_diff, min_continue, min_counter, slot_mask : per-frame settings
//   char_index_c, char_diff_c, char_valid_c         : frame input
//   res_index, res_valid, res_ready                 : result handshake
//   timeout                                         : 1-cycle search abandon pulse
//   busy                                            : FSM not in IDLE
module judge_multi #(
    parameter int N_CHAR = 8,
    parameter int IDX_W  = 4,
    parameter int DIFF_W = 16,
    parameter int CNT_W  = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DIFF_W-1:0]         max_diff,
    input  logic [3:0]                min_continue,
    input  logic [CNT_W-1:0]          min_counter,
    input  logic [N_CHAR-1:0]         slot_mask,
    input  logic [N_CHAR*IDX_W-1:0]   char_index_c,
    input  logic [N_CHAR*DIFF_W-1:0]  char_diff_c,
    input  logic                      char_valid_c,
    output logic [N_CHAR*IDX_W-1:0]   res_index,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic                      timeout,
    output logic                      busy
);

    typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

    function automatic logic [3:0] streak_inc(input logic [3:0] s);
        return (s == 4'hF) ? s : s + 4'd1;
    endfunction

    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
        return (c == '1) ? c : c + CNT_W'(1);
    endfunction

    // Stage 0 -> 1: mask indices, judge the scores, capture per-frame settings
    logic [N_CHAR*IDX_W-1:0] idx_c;
    logic                    good_c;
    logic [3:0]              thr_c;

    always_comb begin
        idx_c  = '0;
        good_c = (slot_mask != '0);
        for (int i = 0; i < N_CHAR; i++) begin
            if (slot_mask[i]) begin
                idx_c[i*IDX_W +: IDX_W] = char_index_c[i*IDX_W +: IDX_W];
                if (char_diff_c[i*DIFF_W +: DIFF_W] > max_diff)
                    good_c = 1'b0;
            end
        end
        thr_c = (min_continue == 4'd0) ? 4'd1 : min_continue;
    end

    logic                    vld_p1;
    logic                    good_p1;
    logic [N_CHAR*IDX_W-1:0] idx_p1;
    logic [3:0]              thr_p1;
`ifdef JUDGE_MULTI_TIMEOUT_EN
    logic [CNT_W-1:0]        min_cnt_p1;
`else
    logic                    unused_min_counter;
    assign unused_min_counter = ^min_counter;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1     <= 1'b0;
            good_p1    <= 1'b0;
            idx_p1     <= '0;
            thr_p1     <= '0;
`ifdef JUDGE_MULTI_TIMEOUT_EN
            min_cnt_p1 <= '0;
`endif
        end else begin
            vld_p1 <= char_valid_c;
            if (char_valid_c) begin
                good_p1    <= good_c;
                idx_p1     <= idx_c;
                thr_p1     <= thr_c;
`ifdef JUDGE_MULTI_TIMEOUT_EN
                min_cnt_p1 <= min_counter;
`endif
            end
        end
    end

    // Stage 1 -> 2: streak tracking state machine
    state_t                  state_p2, state_n;
    logic [N_CHAR*IDX_W-1:0] cand_p2, cand_n;
    logic [3:0]              streak_p2, streak_n;
    logic [CNT_W-1:0]        cnt_p2, cnt_n;
    logic [N_CHAR*IDX_W-1:0] res_idx_p2, res_idx_n;
    logic                    res_vld_p2, res_vld_n;
`ifdef JUDGE_MULTI_TIMEOUT_EN
    logic                    timeout_p2, timeout_n;
`endif
    logic [N_CHAR*IDX_W-1:0] f_cand;
    logic [3:0]              f_streak;

    always_comb begin
        state_n   = state_p2;
        cand_n    = cand_p2;
        streak_n  = streak_p2;
        cnt_n     = cnt_p2;
        res_idx_n = res_idx_p2;
        res_vld_n = res_vld_p2;
`ifdef JUDGE_MULTI_TIMEOUT_EN
        timeout_n = 1'b0;
`endif
        // Candidate/streak as they would be after applying this frame
        f_cand   = cand_p2;
        f_streak = 4'd0;
        if (good_p1) begin
            if (idx_p1 == cand_p2) begin
                f_streak = streak_inc(streak_p2);
            end else begin
                f_cand   = idx_p1;
                f_streak = 4'd1;
            end
        end

        if (state_p2 == DONE) begin
            if (res_vld_p2 && res_ready) begin
                state_n   = IDLE;
                res_vld_n = 1'b0;
                streak_n  = 4'd0;
                cnt_n     = '0;
            end
        end else if (vld_p1) begin
            state_n  = COLLECT;
            cnt_n    = (state_p2 == IDLE) ? CNT_W'(1) : cnt_inc(cnt_p2);
            cand_n   = f_cand;
            streak_n = f_streak;
            // A result takes precedence over an abandoned search
            if (good_p1 && (f_streak >= thr_p1)) begin
                state_n   = DONE;
                res_idx_n = f_cand;
                res_vld_n = 1'b1;
            end
`ifdef JUDGE_MULTI_TIMEOUT_EN
            else if ((min_cnt_p1 != '0) && (cnt_n >= min_cnt_p1)) begin
                state_n   = IDLE;
                timeout_n = 1'b1;
                streak_n  = 4'd0;
                cnt_n     = '0;
                cand_n    = '0;
            end
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_p2   <= IDLE;
            cand_p2    <= '0;
            streak_p2  <= '0;
            cnt_p2     <= '0;
            res_idx_p2 <= '0;
            res_vld_p2 <= 1'b0;
`ifdef JUDGE_MULTI_TIMEOUT_EN
            timeout_p2 <= 1'b0;
`endif
        end else begin
            state_p2   <= state_n;
            cand_p2    <= cand_n;
            streak_p2  <= streak_n;
            cnt_p2     <= cnt_n;
            res_idx_p2 <= res_idx_n;
            res_vld_p2 <= res_vld_n;
`ifdef JUDGE_MULTI_TIMEOUT_EN
            timeout_p2 <= timeout_n;
`endif
        end
    end

    assign res_index = res_idx_p2;
    assign res_valid = res_vld_p2;
    assign busy      = (state_p2 != IDLE);
`ifdef JUDGE_MULTI_TIMEOUT_EN
    assign timeout   = timeout_p2;
`else
    assign timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_judge_multi.sv
// Directed testbench for judge_multi (default parameters). Works with or
// without JUDGE_MULTI_TIMEOUT_EN defined.
module tb_judge_multi;
    localparam int N_CHAR = 8;
    localparam int IDX_W  = 4;
    localparam int DIFF_W = 16;
    localparam int CNT_W  = 8;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [DIFF_W-1:0]         max_diff;
    logic [3:0]                min_continue;
    logic [CNT_W-1:0]          min_counter;
    logic [N_CHAR-1:0]         slot_mask;
    logic [N_CHAR*IDX_W-1:0]   char_index_c;
    logic [N_CHAR*DIFF_W-1:0]  char_diff_c;
    logic                      char_valid_c;
    logic [N_CHAR*IDX_W-1:0]   res_index;
    logic                      res_valid;
    logic                      res_ready;
    logic                      timeout;
    logic                      busy;

    judge_multi #(.N_CHAR(N_CHAR), .IDX_W(IDX_W), .DIFF_W(DIFF_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .max_diff(max_diff), .min_continue(min_continue),
        .min_counter(min_counter), .slot_mask(slot_mask), .char_index_c(char_index_c),
        .char_diff_c(char_diff_c), .char_valid_c(char_valid_c), .res_index(res_index),
        .res_valid(res_valid), .res_ready(res_ready), .timeout(timeout), .busy(busy)
    );

    always #5 clk = ~clk;

    // Slots 7..3 carry 4,3,2,1,0; slots 2..0 carry junk that the mask removes
    localparam logic [31:0]  IDX_BASIC = 32'h4321_0567;
    localparam logic [31:0]  EXP_BASIC = 32'h4321_0000;
    localparam logic [127:0] D_GOOD_F8 = {{5{16'h0010}}, {3{16'hFFFF}}};
    localparam logic [127:0] D_BAD_F8  = {{5{16'h0050}}, {3{16'h0000}}};
    localparam logic [127:0] D_ZERO    = '0;
    localparam logic [31:0]  IDX_A     = 32'h1234_5678;
    localparam logic [31:0]  IDX_B     = 32'h8765_4321;
    localparam logic [31:0]  IDX_C     = 32'h9ABC_DEF0;
    localparam logic [31:0]  IDX_D     = 32'h0F0F_0F0F;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Event counters sampled on the falling edge
    int   rise_cnt = 0;
    int   to_cnt   = 0;
    logic prev_rv  = 1'b0;
    always @(negedge clk) begin
        if (res_valid && !prev_rv) rise_cnt <= rise_cnt + 1;
        if (timeout) to_cnt <= to_cnt + 1;
        prev_rv <= res_valid;
    end

    // Called at a falling edge; returns at the next falling edge
    task automatic send_frame(input logic [31:0] idx, input logic [127:0] diff);
        char_index_c = idx;
        char_diff_c  = diff;
        char_valid_c = 1'b1;
        @(negedge clk);
        char_valid_c = 1'b0;
    endtask

    task automatic handshake();
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    initial begin
        int rise_base;
        int to_base;
        int exp_to;
        rst = 1'b1; max_diff = 16'd30; min_continue = 4'd2; min_counter = '0;
        slot_mask = 8'hF8; char_index_c = '0; char_diff_c = '0;
        char_valid_c = 1'b0; res_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_index", res_index, 0);
        check("rst_timeout", timeout, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        @(negedge clk);

        // Basic: two identical good frames back-to-back
        send_frame(IDX_BASIC, D_GOOD_F8);
        check("basic_busy_stage1", busy, 0);
        send_frame(IDX_BASIC, D_GOOD_F8);
        check("basic_busy", busy, 1);
        check("basic_early_valid", res_valid, 0);
        @(negedge clk);
        check("basic_valid", res_valid, 1);
        check("basic_index", res_index, EXP_BASIC);
        handshake();
        check("basic_release_valid", res_valid, 0);
        check("basic_release_busy", busy, 0);

        // Mismatch: A,B,A,A -> one result equal to A on the 4th frame
        slot_mask = 8'hFF;
        rise_base = rise_cnt;
        send_frame(IDX_A, D_ZERO);
        send_frame(IDX_B, D_ZERO);
        send_frame(IDX_A, D_ZERO);
        send_frame(IDX_A, D_ZERO);
        check("mm_valid_3rd", res_valid, 0);
        @(negedge clk);
        check("mm_valid_4th", res_valid, 1);
        check("mm_index", res_index, IDX_A);
        repeat (2) @(negedge clk);
        check("mm_one_result", rise_cnt - rise_base, 1);
        handshake();

        // Backpressure: frames arriving in DONE are dropped
        send_frame(IDX_C, D_ZERO);
        send_frame(IDX_C, D_ZERO);
        @(negedge clk);
        check("bp_valid", res_valid, 1);
        for (int c = 0; c < 20; c++) begin
            if (c == 2 || c == 8 || c == 14) send_frame(IDX_D, D_ZERO);
            else @(negedge clk);
        end
        check("bp_hold_valid", res_valid, 1);
        check("bp_hold_index", res_index, IDX_C);
        check("bp_hold_busy", busy, 1);
        handshake();
        check("bp_release_valid", res_valid, 0);
        check("bp_release_busy", busy, 0);
        send_frame(IDX_D, D_ZERO);
        repeat (2) @(negedge clk);
        check("bp_single_after", res_valid, 0);

        // Reset mid-search
        slot_mask = 8'hF8;
        send_frame(IDX_BASIC, D_GOOD_F8);
        @(negedge clk);
        check("rms_busy_before", busy, 1);
        rst = 1'b1;
        #1;
        check("rms_res_valid", res_valid, 0);
        check("rms_res_index", res_index, 0);
        check("rms_timeout", timeout, 0);
        check("rms_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send_frame(IDX_BASIC, D_GOOD_F8);
        repeat (3) @(negedge clk);
        check("rms_single_no_result", res_valid, 0);
        check("rms_index_still_0", res_index, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Bad diffs: 12 bad frames with min_counter=10, then 2 good ones
        min_counter = 8'd10;
        rise_base = rise_cnt;
        to_base   = to_cnt;
`ifdef JUDGE_MULTI_TIMEOUT_EN
        exp_to = 1;
`else
        exp_to = 0;
`endif
        for (int k = 1; k <= 12; k++) begin
            send_frame(IDX_BASIC, D_BAD_F8);
            @(negedge clk);
            check($sformatf("bad_timeout_f%0d", k), timeout, (exp_to == 1 && k == 10) ? 1 : 0);
            check($sformatf("bad_busy_f%0d", k), busy, (exp_to == 1 && k == 10) ? 0 : 1);
        end
        check("bad_no_result", rise_cnt - rise_base, 0);
        send_frame(IDX_BASIC, D_GOOD_F8);
        send_frame(IDX_BASIC, D_GOOD_F8);
        check("bad_valid_13th", res_valid, 0);
        @(negedge clk);
        check("bad_valid_14th", res_valid, 1);
        check("bad_index_14th", res_index, EXP_BASIC);
        repeat (2) @(negedge clk);
        check("bad_timeout_count", to_cnt - to_base, exp_to);
        handshake();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
